// File: rtl/sevenseg_scan.sv
// Time-multiplexed scan controller for a common-anode seven-segment display.
// New values are double-buffered and only swapped in on frame boundaries.
module sevenseg_scan #(
  parameter int NDIGITS      = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic [4*NDIGITS-1:0]   value,
  input  logic [NDIGITS-1:0]     dp_in,
  input  logic [NDIGITS-1:0]     digit_en,
  input  logic                   lz_blank,
  output logic [3:0]             digit,
  output logic                   dp,
  output logic [NDIGITS-1:0]     an,
  output logic                   frame_tick,
  output logic                   pending
);

  localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam int CW = $clog2(REFRESH_DIV);

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } phase_t;

  logic [CW-1:0]          cnt;
  logic [IW-1:0]          idx;
  logic [4*NDIGITS-1:0]   pend_val;
  logic [NDIGITS-1:0]     pend_dp;
  logic                   pend_flag;
  logic [4*NDIGITS-1:0]   act_val;
  logic [NDIGITS-1:0]     act_dp;
  logic                   slot_end;
  logic                   frame_end;
  phase_t                 phase;
  logic [NDIGITS-1:0]     supp;
  logic                   cur_supp;
  logic                   cur_dp;
  logic                   drive;

  assign slot_end  = (cnt == CW'(REFRESH_DIV - 1));
  assign frame_end = slot_end && (idx == IW'(NDIGITS - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      idx        <= '0;
      pend_val   <= '0;
      pend_dp    <= '0;
      pend_flag  <= 1'b0;
      act_val    <= '0;
      act_dp     <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= frame_end;
      if (slot_end) begin
        cnt <= '0;
        idx <= frame_end ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      if (load) begin
        pend_val <= value;
        pend_dp  <= dp_in;
      end
      // A load landing on the frame-end edge bypasses the pending buffer.
      if (frame_end) begin
        if (load) begin
          act_val <= value;
          act_dp  <= dp_in;
        end else if (pend_flag) begin
          act_val <= pend_val;
          act_dp  <= pend_dp;
        end
        pend_flag <= 1'b0;
      end else if (load) begin
        pend_flag <= 1'b1;
      end
    end
  end

  assign phase   = (int'(cnt) < BLANK_CYCLES) ? BLANK : DRIVE;
  assign pending = pend_flag;

  // A position is zero-suppressed when it and everything to its left is zero.
  always_comb begin
    logic all_zero;
    all_zero = 1'b1;
    supp     = '0;
    for (int i = NDIGITS - 1; i >= 0; i--) begin
      all_zero = all_zero & (act_val[4*i +: 4] == 4'h0);
      supp[i]  = ~digit_en[i] | (lz_blank & all_zero & (i != 0));
    end
  end

  always_comb begin
    digit    = 4'h0;
    cur_dp   = 1'b0;
    cur_supp = 1'b0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (idx == IW'(i)) begin
        digit    = act_val[4*i +: 4];
        cur_dp   = act_dp[i];
        cur_supp = supp[i];
      end
    end
  end

  assign drive = ~reset & (phase == DRIVE) & ~cur_supp;
  assign dp    = drive & cur_dp;

  always_comb begin
    an = '1;
    for (int i = 0; i < NDIGITS; i++) begin
      if (drive && idx == IW'(i)) an[i] = 1'b0;
    end
  end

endmodule

// File: tb/tb_sevenseg_scan.sv
// Randomized bench for sevenseg_scan against a time-indexed behavioural model.
// The model derives slot/phase from the cycle count since reset release.
module tb_sevenseg_scan;

  localparam int ND = 4;
  localparam int RD = 8;
  localparam int BC = 2;
  localparam int FRAME = ND * RD;

  logic          clk;
  logic          reset;
  logic          load;
  logic [15:0]   value;
  logic [3:0]    dp_in;
  logic [3:0]    digit_en;
  logic          lz_blank;
  logic [3:0]    digit;
  logic          dp;
  logic [3:0]    an;
  logic          frame_tick;
  logic          pending;

  int checks;
  int errors;

  int          t;
  logic [15:0] mAct;
  logic [3:0]  mActDp;
  logic [15:0] mPend;
  logic [3:0]  mPendDp;
  bit          mFlag;

  sevenseg_scan #(
    .NDIGITS(ND),
    .REFRESH_DIV(RD),
    .BLANK_CYCLES(BC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .load(load),
    .value(value),
    .dp_in(dp_in),
    .digit_en(digit_en),
    .lz_blank(lz_blank),
    .digit(digit),
    .dp(dp),
    .an(an),
    .frame_tick(frame_tick),
    .pending(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s at t=%0d: got %0h expected %0h", tag, t, obs, exp);
    end
  endtask

  task automatic checkReset();
    checkOutput("rst_an", 32'(an), 32'hF);
    checkOutput("rst_digit", 32'(digit), 32'h0);
    checkOutput("rst_dp", 32'(dp), 32'h0);
    checkOutput("rst_tick", 32'(frame_tick), 32'h0);
    checkOutput("rst_pending", 32'(pending), 32'h0);
  endtask

  // Expected outputs for the current cycle, from position-in-frame arithmetic.
  task automatic checkCycle();
    int c, s;
    bit blank, supp, drv;
    logic [3:0] expAn, expDigit;
    c        = t % RD;
    s        = (t / RD) % ND;
    blank    = (c < BC);
    supp     = !digit_en[s] || (lz_blank && s != 0 && (mAct >> (4 * s)) == 16'h0);
    drv      = !blank && !supp;
    expAn    = drv ? ~(4'b0001 << s) : 4'hF;
    expDigit = 4'((mAct >> (4 * s)) & 16'hF);
    checkOutput("an", 32'(an), 32'(expAn));
    checkOutput("digit", 32'(digit), 32'(expDigit));
    checkOutput("dp", 32'(dp), 32'(drv && mActDp[s]));
    checkOutput("frame_tick", 32'(frame_tick), 32'(t > 0 && t % FRAME == 0));
    checkOutput("pending", 32'(pending), 32'(mFlag));
  endtask

  task automatic modelEdge(input bit ld, input logic [15:0] v, input logic [3:0] d);
    if (t % FRAME == FRAME - 1) begin
      if (ld) begin
        mAct   = v;
        mActDp = d;
      end else if (mFlag) begin
        mAct   = mPend;
        mActDp = mPendDp;
      end
      mFlag = 0;
    end else if (ld) begin
      mPend   = v;
      mPendDp = d;
      mFlag   = 1;
    end
    t++;
  endtask

  task automatic applyStimulus(input bit ld, input logic [15:0] v, input logic [3:0] d);
    load  = ld;
    value = v;
    dp_in = d;
    modelEdge(ld, v, d);
    @(posedge clk);
    #1 load = 1'b0;
    @(negedge clk);
    checkCycle();
  endtask

  task automatic doReset();
    #1 reset = 1'b1;
    #1 checkReset();
    @(posedge clk);
    #1 checkReset();
    @(negedge clk);
    #1 reset = 1'b0;
    t = 0; mAct = '0; mActDp = '0; mPend = '0; mPendDp = '0; mFlag = 0;
    checkCycle();
  endtask

  initial begin
    checks = 0; errors = 0;
    t = 0; mAct = '0; mActDp = '0; mPend = '0; mPendDp = '0; mFlag = 0;
    reset = 1'b1; load = 1'b0; value = '0; dp_in = '0;
    digit_en = 4'hF; lz_blank = 1'b0;

    doReset();
    repeat (40) applyStimulus(0, 16'h0, 4'h0);

    doReset();
    for (int k = 0; k < 64; k++) applyStimulus(t == 5, 16'h1A2F, 4'b0100);

    for (int k = 0; k < 64; k++) begin
      if (t % FRAME == 3)      applyStimulus(1, 16'h1111, 4'b0001);
      else if (t % FRAME == 9) applyStimulus(1, 16'h2222, 4'b0010);
      else                     applyStimulus(0, 16'h0, 4'h0);
    end

    for (int k = 0; k < 64; k++) applyStimulus(t % FRAME == FRAME - 1, 16'h3333, 4'b1000);

    for (int k = 0; k < 40; k++) applyStimulus(t % FRAME == 10, 16'h0070, 4'b0000);
    lz_blank = 1'b1;
    repeat (40) applyStimulus(0, 16'h0, 4'h0);
    lz_blank = 1'b0;
    repeat (40) applyStimulus(0, 16'h0, 4'h0);

    digit_en = 4'b1011;
    doReset();
    for (int k = 0; k < 52; k++) applyStimulus(t == 40, 16'hBEEF, 4'b1111);
    doReset();
    repeat (40) applyStimulus(0, 16'h0, 4'h0);
    digit_en = 4'hF;

    for (int k = 0; k < 2500; k++) begin
      bit ld;
      if (k % 64 == 0)  digit_en = 4'($urandom_range(0, 15)) | 4'b0001;
      if (k % 100 == 0) lz_blank = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 999) == 0) doReset();
      if (t % FRAME == FRAME - 1) ld = ($urandom_range(0, 1) == 1);
      else                        ld = ($urandom_range(0, 15) == 0);
      applyStimulus(ld, 16'($urandom_range(0, 255) == 0 ? 0 : $urandom_range(0, 16'hFFFF) >> $urandom_range(0, 12)),
                    4'($urandom_range(0, 15)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
